// File: rtl/trace_packetizer.sv
// trace_packetizer: keeps the trace items the filter did not drop, buffers them in a
// FIFO and streams them out as AXI-Stream packets framed by tlast.
module trace_packetizer #(
   parameter int DEPTH        = 16,
   parameter int PACKET_ITEMS = 8,
   parameter int TIMEOUT      = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     trace_valid,
   input  logic [63:0]              pc,
   input  logic [31:0]              instr,
   input  logic                     drop_instr,
   input  logic                     flush,
   output logic [95:0]              m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic [31:0]              overflow_count,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (PACKET_ITEMS > 1) ? $clog2(PACKET_ITEMS) : 1;
   localparam int IW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [BW-1:0] LAST_BEAT  = BW'(PACKET_ITEMS - 1);
   localparam logic [IW-1:0] IDLE_MAX   = IW'(TIMEOUT);

   logic [95:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [BW-1:0] beat_cnt;
   logic [IW-1:0] idle_cnt;
   logic          flush_pending;
   logic          held;
   logic          wr_req;
   logic          pop;
   logic          wr_ok;
   logic          timeout_hit;
   logic          present;
   logic          present_last;

   // Output handshake: a beat transfers at a rising edge where tvalid & tready are both 1.
   // Once tvalid rises, tvalid/tdata/tlast stay constant until that transfer happens.
   assign m_axis_tvalid = held;
   assign wr_req        = en & trace_valid & ~drop_instr;
   assign pop           = held & m_axis_tready;
   assign wr_ok         = wr_req & ((fifo_count < FULL_COUNT) | pop);
   assign timeout_hit   = (idle_cnt == IDLE_MAX);

   // A lone item is only sent once the stream has gone quiet or a flush asks for it,
   // so that short bursts still pack into full packets.
   always_comb begin
      present      = 1'b0;
      present_last = 1'b0;
      if (!held) begin
         if (fifo_count >= CW'(2)) begin
            present      = 1'b1;
            present_last = (beat_cnt == LAST_BEAT);
         end else if ((fifo_count == CW'(1)) && (timeout_hit || flush_pending)) begin
            present      = 1'b1;
            present_last = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= {pc, instr};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         fifo_count     <= '0;
         held           <= 1'b0;
         m_axis_tdata   <= '0;
         m_axis_tlast   <= 1'b0;
         beat_cnt       <= '0;
         idle_cnt       <= '0;
         flush_pending  <= 1'b0;
         overflow_count <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end

         unique case ({wr_ok, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase

         if (pop) begin
            held     <= 1'b0;
            beat_cnt <= m_axis_tlast ? '0 : beat_cnt + BW'(1);
         end else if (present) begin
            held         <= 1'b1;
            m_axis_tdata <= mem[rd_ptr];
            m_axis_tlast <= present_last;
         end

         if (wr_ok) begin
            idle_cnt <= '0;
         end else if (!timeout_hit) begin
            idle_cnt <= idle_cnt + IW'(1);
         end

         // A new flush request wins over the clear conditions of an older one.
         flush_pending <= flush |
                          (flush_pending & ~(pop & m_axis_tlast) & (fifo_count != '0));

         if (wr_req && !wr_ok && (overflow_count != 32'hFFFF_FFFF)) begin
            overflow_count <= overflow_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_trace_packetizer.sv
// Bench for trace_packetizer: queue-based reference model checked every cycle,
// a vector table, directed multi-cycle sequences and a randomized run.
module tb_trace_packetizer;
   localparam int DEPTH        = 16;
   localparam int PACKET_ITEMS = 8;
   localparam int TIMEOUT      = 1024;
   localparam int CW           = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          trace_valid;
   logic [63:0]   pc;
   logic [31:0]   instr;
   logic          drop_instr;
   logic          flush;
   logic [95:0]   m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          m_axis_tlast;
   logic [31:0]   overflow_count;
   logic [CW-1:0] fifo_count;

   always #5 clk = ~clk;

   trace_packetizer #(
      .DEPTH(DEPTH),
      .PACKET_ITEMS(PACKET_ITEMS),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .trace_valid(trace_valid),
      .pc(pc),
      .instr(instr),
      .drop_instr(drop_instr),
      .flush(flush),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast),
      .overflow_count(overflow_count),
      .fifo_count(fifo_count)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: exp_q holds the buffered items, head first.
   logic [95:0] exp_q[$];
   logic        m_valid = 1'b0;
   logic        m_last  = 1'b0;
   logic [95:0] m_data  = '0;
   int          m_beat  = 0;
   int          m_idle  = 0;
   logic        m_flush = 1'b0;
   logic [31:0] m_ovf   = '0;

   // Beats actually taken from the DUT.
   logic [95:0] out_data[$];
   logic        out_last[$];
   int          out_cyc[$];

   typedef struct {
      logic          drop;
      logic [63:0]   pc;
      logic [CW-1:0] exp_count;
      logic          exp_valid;
   } vec_t;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [95:0] item_of(input logic [63:0] p);
      return {p, p[31:0] ^ 32'hA5A5_0000};
   endfunction

   task automatic model_step();
      logic pop;
      logic wr;
      logic acc;
      logic pres;
      logic pres_last;
      int   sz;
      if (rst) begin
         exp_q.delete();
         m_valid = 1'b0; m_last = 1'b0; m_data = '0;
         m_beat = 0; m_idle = 0; m_flush = 1'b0; m_ovf = '0;
         return;
      end
      sz        = exp_q.size();
      pop       = m_valid && m_axis_tready;
      wr        = en && trace_valid && !drop_instr;
      acc       = wr && ((sz < DEPTH) || pop);
      pres      = 1'b0;
      pres_last = 1'b0;
      if (!m_valid && sz >= 2) begin
         pres = 1'b1;
         pres_last = (m_beat == PACKET_ITEMS - 1);
      end else if (!m_valid && sz == 1 && (m_idle == TIMEOUT || m_flush)) begin
         pres = 1'b1;
         pres_last = 1'b1;
      end
      m_flush = flush || (m_flush && !(pop && m_last) && sz != 0);
      if (pop) begin
         void'(exp_q.pop_front());
         m_beat  = m_last ? 0 : m_beat + 1;
         m_valid = 1'b0;
      end else if (pres) begin
         m_valid = 1'b1;
         m_data  = exp_q[0];
         m_last  = pres_last;
      end
      if (acc) begin
         exp_q.push_back({pc, instr});
         m_idle = 0;
      end else if (m_idle < TIMEOUT) begin
         m_idle++;
      end
      if (wr && !acc && m_ovf != 32'hFFFF_FFFF) m_ovf++;
   endtask

   task automatic check_outputs();
      chk("fifo_count", 96'(fifo_count), 96'(exp_q.size()));
      chk("tvalid", 96'(m_axis_tvalid), 96'(m_valid));
      chk("overflow_count", 96'(overflow_count), 96'(m_ovf));
      if (m_valid) begin
         chk("tdata", m_axis_tdata, m_data);
         chk("tlast", 96'(m_axis_tlast), 96'(m_last));
      end
   endtask

   // One clock: log a handshake, advance the model at the edge, check at the falling edge.
   task automatic tick();
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         out_data.push_back(m_axis_tdata);
         out_last.push_back(m_axis_tlast);
         out_cyc.push_back(cyc);
      end
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle_in();
      en = 1'b0; trace_valid = 1'b0; drop_instr = 1'b0; flush = 1'b0;
   endtask

   task automatic put(input logic [63:0] p);
      en = 1'b1; trace_valid = 1'b1; drop_instr = 1'b0; pc = p; instr = p[31:0] ^ 32'hA5A5_0000;
      tick();
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      m_axis_tready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_data.delete(); out_last.delete(); out_cyc.delete();
   endtask

   task automatic wait_beats(input int n, input int budget, input string name);
      int k = 0;
      while (out_data.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(name, 96'(out_data.size()), 96'(n));
   endtask

   initial begin
      vec_t vecs[10];
      int   last_wr;
      int   ready_pct;
      int   k;

      rst = 1'b1; en = 1'b0; trace_valid = 1'b0; drop_instr = 1'b0; flush = 1'b0;
      m_axis_tready = 1'b0; pc = '0; instr = '0;
      @(negedge clk);
      tick();
      tick();
      rst = 1'b0;
      chk("rst_tvalid", 96'(m_axis_tvalid), 96'(0));
      chk("rst_tlast", 96'(m_axis_tlast), 96'(0));
      chk("rst_tdata", m_axis_tdata, 96'(0));
      chk("rst_count", 96'(fifo_count), 96'(0));
      chk("rst_ovf", 96'(overflow_count), 96'(0));

      // 20 back-to-back items: full packets, then a lone tail closed by the timeout.
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 20; i++) put(64'h1000 + 64'(4 * i));
      idle_in();
      last_wr = cyc;
      while (cyc - last_wr < 1000) tick();
      chk("tc1_tail_waiting", 96'(out_data.size()), 96'(19));
      wait_beats(20, 100, "tc1_beats");
      for (int i = 0; i < 20; i++) begin
         chk("tc1_data", out_data[i], item_of(64'h1000 + 64'(4 * i)));
         chk("tc1_last", 96'(out_last[i]), 96'(i == 7 || i == 15 || i == 19));
      end
      chk("tc1_tail_after_timeout", 96'((out_cyc[19] - last_wr) >= TIMEOUT), 96'(1));

      // Alternating drop: only odd-indexed items are kept.
      vecs[0] = '{1'b1, 64'h2000, 5'd0, 1'b0};
      vecs[1] = '{1'b0, 64'h2004, 5'd1, 1'b0};
      vecs[2] = '{1'b1, 64'h2008, 5'd1, 1'b0};
      vecs[3] = '{1'b0, 64'h200C, 5'd2, 1'b0};
      vecs[4] = '{1'b1, 64'h2010, 5'd2, 1'b1};
      vecs[5] = '{1'b0, 64'h2014, 5'd3, 1'b1};
      vecs[6] = '{1'b1, 64'h2018, 5'd3, 1'b1};
      vecs[7] = '{1'b0, 64'h201C, 5'd4, 1'b1};
      vecs[8] = '{1'b1, 64'h2020, 5'd4, 1'b1};
      vecs[9] = '{1'b0, 64'h2024, 5'd5, 1'b1};
      do_reset();
      for (int i = 0; i < 10; i++) begin
         en = 1'b1; trace_valid = 1'b1; drop_instr = vecs[i].drop;
         pc = vecs[i].pc; instr = vecs[i].pc[31:0] ^ 32'hA5A5_0000;
         tick();
         chk("tc2_count", 96'(fifo_count), 96'(vecs[i].exp_count));
         chk("tc2_valid", 96'(m_axis_tvalid), 96'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) chk("tc2_head", m_axis_tdata, item_of(64'h2004));
      end
      idle_in();
      m_axis_tready = 1'b1;
      wait_beats(5, 1200, "tc2_beats");
      for (int i = 0; i < 20; i++) tick();
      chk("tc2_no_extra", 96'(out_data.size()), 96'(5));
      for (int i = 0; i < 5; i++) chk("tc2_data", out_data[i], item_of(64'h2004 + 64'(8 * i)));
      chk("tc2_ovf", 96'(overflow_count), 96'(0));

      // Stalled sink: 20 items into 16 entries, then drain.
      do_reset();
      for (int i = 0; i < 20; i++) put(64'h3000 + 64'(4 * i));
      idle_in();
      tick();
      chk("tc3_full", 96'(fifo_count), 96'(16));
      chk("tc3_ovf", 96'(overflow_count), 96'(4));
      m_axis_tready = 1'b1;
      wait_beats(16, 1300, "tc3_beats");
      for (int i = 0; i < 16; i++) chk("tc3_data", out_data[i], item_of(64'h3000 + 64'(4 * i)));
      chk("tc3_ovf_kept", 96'(overflow_count), 96'(4));

      // Flush closes a 3-item packet early; the following packet starts at beat 0.
      do_reset();
      for (int i = 0; i < 3; i++) put(64'h4000 + 64'(4 * i));
      idle_in();
      tick(); tick(); tick();
      m_axis_tready = 1'b1;
      pulse_flush();
      wait_beats(3, 30, "tc4_flush_beats");
      chk("tc4_last0", 96'(out_last[0]), 96'(0));
      chk("tc4_last1", 96'(out_last[1]), 96'(0));
      chk("tc4_last2", 96'(out_last[2]), 96'(1));
      for (int i = 0; i < 9; i++) put(64'h4100 + 64'(4 * i));
      idle_in();
      wait_beats(11, 60, "tc4_next_packet");
      pulse_flush();
      wait_beats(12, 30, "tc4_tail");
      for (int i = 3; i < 12; i++) chk("tc4_next_last", 96'(out_last[i]), 96'(i == 10 || i == 11));

      // A held beat stays frozen while new items arrive behind it.
      do_reset();
      put(64'h5000);
      idle_in();
      k = 0;
      while (!m_axis_tvalid && k < 1100) begin tick(); k++; end
      chk("tc5_valid", 96'(m_axis_tvalid), 96'(1));
      chk("tc5_last", 96'(m_axis_tlast), 96'(1));
      put(64'h5004);
      put(64'h5008);
      idle_in();
      tick(); tick(); tick();
      chk("tc5_hold_data", m_axis_tdata, item_of(64'h5000));
      chk("tc5_hold_last", 96'(m_axis_tlast), 96'(1));
      chk("tc5_hold_count", 96'(fifo_count), 96'(3));
      m_axis_tready = 1'b1;
      wait_beats(2, 30, "tc5_second");
      pulse_flush();
      wait_beats(3, 30, "tc5_third");
      chk("tc5_d1", out_data[1], item_of(64'h5004));
      chk("tc5_l1", 96'(out_last[1]), 96'(0));
      chk("tc5_l2", 96'(out_last[2]), 96'(1));

      // Full FIFO: write with simultaneous pop is accepted; then reset mid-packet.
      do_reset();
      for (int i = 0; i < 16; i++) put(64'h6000 + 64'(4 * i));
      idle_in();
      tick();
      chk("tc6_full", 96'(fifo_count), 96'(16));
      chk("tc6_valid", 96'(m_axis_tvalid), 96'(1));
      m_axis_tready = 1'b1;
      put(64'h6100);
      m_axis_tready = 1'b0;
      chk("tc6_count_same", 96'(fifo_count), 96'(16));
      chk("tc6_ovf_same", 96'(overflow_count), 96'(0));
      put(64'h6104);
      idle_in();
      chk("tc6_ovf_one", 96'(overflow_count), 96'(1));
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("tc6_rst_valid", 96'(m_axis_tvalid), 96'(0));
      chk("tc6_rst_count", 96'(fifo_count), 96'(0));
      chk("tc6_rst_ovf", 96'(overflow_count), 96'(0));
      chk("tc6_rst_last", 96'(m_axis_tlast), 96'(0));
      chk("tc6_rst_data", m_axis_tdata, 96'(0));

      // Randomized traffic with varying sink throughput.
      do_reset();
      ready_pct = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 250 == 0) ready_pct = (i / 250 % 3 == 0) ? 10 : ((i / 250 % 3 == 1) ? 90 : 50);
         en            = ($urandom_range(0, 9) != 0);
         trace_valid   = ($urandom_range(0, 3) != 0);
         drop_instr    = ($urandom_range(0, 2) == 0);
         flush         = ($urandom_range(0, 63) == 0);
         pc            = {$urandom, $urandom};
         instr         = $urandom;
         m_axis_tready = ($urandom_range(0, 99) < ready_pct);
         tick();
      end
      idle_in();
      m_axis_tready = 1'b1;
      for (int i = 0; i < 40; i++) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
